// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: keypad entry sequencer that builds BCD operands, latches the operator and hands off to the ALU.
// Optional build macro KEY_BUFFER_EN adds a one-entry buffer for keys pressed while the ALU is busy.
module calc_entry_ctrl #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    output logic              key_ready,
    output logic [4*NDIG-1:0] opa,
    output logic [4*NDIG-1:0] opb,
    output logic              op_sub,
    output logic              alu_req,
    input  logic              alu_ack,
    input  logic [4*NDIG-1:0] alu_result,
    output logic [4*NDIG-1:0] disp,
    output logic              digit_ovf,
    output logic [1:0]        state
);
    localparam int W  = 4 * NDIG;
    localparam int CW = $clog2(NDIG + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(NDIG);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [3:0] K_ADD = 4'hA;
    localparam logic [3:0] K_SUB = 4'hB;
    localparam logic [3:0] K_EQ  = 4'hC;
    localparam logic [3:0] K_CLR = 4'hD;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        REQ     = 2'd2,
        SHOW    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  opa_q, opa_d, opb_q, opb_d, res_q, res_d;
    logic [CW-1:0] cnta_q, cnta_d, cntb_q, cntb_d;
    logic          op_sub_q, op_sub_d;
    logic          alu_req_q, alu_req_d;
    logic          ovf_q, ovf_d;
    logic          from_buf;
    logic          take;
    logic [3:0]    k;

`ifdef KEY_BUFFER_EN
    logic       buf_vld_q, buf_vld_d;
    logic [3:0] buf_key_q, buf_key_d;

    // The buffered key replays in the first SHOW cycle; external keys stall while it is held.
    assign from_buf  = (state_q == SHOW) && buf_vld_q;
    assign key_ready = !buf_vld_q;
    assign k         = from_buf ? buf_key_q : key_code;
`else
    assign from_buf  = 1'b0;
    assign key_ready = (state_q != REQ);
    assign k         = key_code;
`endif

    assign take = from_buf || (key_valid && key_ready && (state_q != REQ));

    function automatic logic [W-1:0] push_digit(input logic [W-1:0] op, input logic [3:0] d);
        return (op << 4) | W'(d);
    endfunction

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        res_d     = res_q;
        cnta_d    = cnta_q;
        cntb_d    = cntb_q;
        op_sub_d  = op_sub_q;
        alu_req_d = alu_req_q;
        ovf_d     = ovf_q;
`ifdef KEY_BUFFER_EN
        buf_vld_d = buf_vld_q;
        buf_key_d = buf_key_q;
        if (from_buf) buf_vld_d = 1'b0;
`endif
        if (state_q == REQ) begin
            if (alu_ack) begin
                res_d     = alu_result;
                alu_req_d = 1'b0;
                state_d   = SHOW;
            end
`ifdef KEY_BUFFER_EN
            if (key_valid) begin
                if (!buf_vld_q) begin
                    buf_vld_d = 1'b1;
                    buf_key_d = key_code;
                end else begin
                    ovf_d = 1'b1;
                end
            end
`endif
        end else if (take) begin
            if (k == K_CLR) begin
                state_d   = ENTER_A;
                opa_d     = '0;
                opb_d     = '0;
                res_d     = '0;
                cnta_d    = '0;
                cntb_d    = '0;
                op_sub_d  = 1'b0;
                alu_req_d = 1'b0;
                ovf_d     = 1'b0;
            end else if (k <= 4'h9) begin
                case (state_q)
                    SHOW: begin
                        opa_d   = W'(k);
                        cnta_d  = CNT_ONE;
                        // A replayed key keeps the overflow raised by keys dropped during REQ.
                        ovf_d   = from_buf ? ovf_q : 1'b0;
                        state_d = ENTER_A;
                    end
                    ENTER_B: begin
                        if (cntb_q < CNT_FULL) begin
                            opb_d  = push_digit(opb_q, k);
                            cntb_d = cntb_q + CNT_ONE;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    default: begin
                        if (cnta_q < CNT_FULL) begin
                            opa_d  = push_digit(opa_q, k);
                            cnta_d = cnta_q + CNT_ONE;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                endcase
            end else if ((k == K_ADD) || (k == K_SUB)) begin
                op_sub_d = (k == K_SUB);
                if (state_q == ENTER_A) begin
                    opb_d   = '0;
                    cntb_d  = '0;
                    state_d = ENTER_B;
                end else if (state_q == SHOW) begin
                    opa_d   = res_q;
                    cnta_d  = CNT_FULL;
                    opb_d   = '0;
                    cntb_d  = '0;
                    state_d = ENTER_B;
                end
            end else if (k == K_EQ) begin
                if (state_q == ENTER_B) begin
                    state_d   = REQ;
                    alu_req_d = 1'b1;
                end else if (state_q == SHOW) begin
                    opa_d     = res_q;
                    cnta_d    = CNT_FULL;
                    state_d   = REQ;
                    alu_req_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ENTER_A;
            opa_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
            cnta_q    <= '0;
            cntb_q    <= '0;
            op_sub_q  <= 1'b0;
            alu_req_q <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef KEY_BUFFER_EN
            buf_vld_q <= 1'b0;
            buf_key_q <= 4'h0;
`endif
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            res_q     <= res_d;
            cnta_q    <= cnta_d;
            cntb_q    <= cntb_d;
            op_sub_q  <= op_sub_d;
            alu_req_q <= alu_req_d;
            ovf_q     <= ovf_d;
`ifdef KEY_BUFFER_EN
            buf_vld_q <= buf_vld_d;
            buf_key_q <= buf_key_d;
`endif
        end
    end

    always_comb begin
        case (state_q)
            ENTER_A: disp = opa_q;
            ENTER_B: disp = opb_q;
            default: disp = res_q;
        endcase
    end

    assign opa       = opa_q;
    assign opb       = opb_q;
    assign op_sub    = op_sub_q;
    assign alu_req   = alu_req_q;
    assign digit_ovf = ovf_q;
    assign state     = state_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl; ALU requests are checked against a scoreboard of expected operands.
module tb_calc_entry_ctrl;
    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_valid;
    logic [3:0]   key_code;
    logic         key_ready;
    logic [W-1:0] opa, opb, disp, alu_result;
    logic         op_sub, alu_req, alu_ack, digit_ovf;
    logic [1:0]   state;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
    } req_t;

    req_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    calc_entry_ctrl #(.NDIG(NDIG)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .opa(opa), .opb(opb), .op_sub(op_sub),
        .alu_req(alu_req), .alu_ack(alu_ack), .alu_result(alu_result),
        .disp(disp), .digit_ovf(digit_ovf), .state(state)
    );

    always #5 clk = ~clk;

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; the key is consumed at the next posedge and the task returns at the following negedge.
    task automatic key(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic press_eq(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        req_t r;
        r.a = a; r.b = b; r.sub = sub;
        exp_q.push_back(r);
        chk("req_low_before_eq", W'(alu_req), W'(0));
        key(4'hC);
    endtask

    // Pops the expected request, checks it, holds the ALU busy, then acks with the modelled result.
    task automatic serve(input int hold);
        req_t         r;
        int           res;
        int           waited = 0;
        logic [W-1:0] rb;
        while (!alu_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("req_seen", W'(alu_req), W'(1));
        if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", W'(0), W'(1));
            return;
        end
        r = exp_q.pop_front();
        chk("req_opa", opa, r.a);
        chk("req_opb", opb, r.b);
        chk("req_sub", W'(op_sub), W'(r.sub));
        chk("req_state", W'(state), W'(2));
        for (int i = 0; i < hold; i++) begin
            chk("hold_req", W'(alu_req), W'(1));
            chk("hold_ready", W'(key_ready), W'(0));
            chk("hold_opa", opa, r.a);
            chk("hold_opb", opb, r.b);
            @(negedge clk);
        end
        res = r.sub ? (bcd2int(r.a) - bcd2int(r.b) + 10000) % 10000
                    : (bcd2int(r.a) + bcd2int(r.b)) % 10000;
        rb = int2bcd(res);
        alu_ack    = 1'b1;
        alu_result = rb;
        @(negedge clk);
        alu_ack    = 1'b0;
        alu_result = 16'h0000;
        chk("show_disp", disp, rb);
        chk("show_state", W'(state), W'(3));
        chk("show_req", W'(alu_req), W'(0));
    endtask

    initial begin
        reset      = 1'b1;
        key_valid  = 1'b0;
        key_code   = 4'h0;
        alu_ack    = 1'b0;
        alu_result = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_state", W'(state), W'(0));
        chk("rst_opa", opa, W'(0));
        chk("rst_opb", opb, W'(0));
        chk("rst_disp", disp, W'(0));
        chk("rst_req", W'(alu_req), W'(0));
        chk("rst_ovf", W'(digit_ovf), W'(0));
        chk("rst_sub", W'(op_sub), W'(0));
        chk("rst_ready", W'(key_ready), W'(1));

        // 12 + 3
        key(4'h1); chk("a1_opa", opa, 16'h0001); chk("a1_disp", disp, 16'h0001);
        key(4'h2); chk("a12_opa", opa, 16'h0012);
        key(4'hA); chk("opA_state", W'(state), W'(1)); chk("opA_disp", disp, W'(0));
        key(4'h3); chk("b3_opb", opb, 16'h0003); chk("b3_disp", disp, 16'h0003);
        press_eq(16'h0012, 16'h0003, 1'b0);
        chk("eq_req_next", W'(alu_req), W'(1));
        serve(0);

        // Overflow on the fifth digit, then clear
        key(4'h9); chk("show_digit_state", W'(state), W'(0)); chk("show_digit_opa", opa, 16'h0009);
        key(4'h8); key(4'h7); key(4'h6);
        chk("full_opa", opa, 16'h9876); chk("full_ovf", W'(digit_ovf), W'(0));
        key(4'h5); chk("ovf_opa", opa, 16'h9876); chk("ovf_set", W'(digit_ovf), W'(1));
        key(4'hD);
        chk("clr_opa", opa, W'(0)); chk("clr_opb", opb, W'(0)); chk("clr_disp", disp, W'(0));
        chk("clr_ovf", W'(digit_ovf), W'(0)); chk("clr_state", W'(state), W'(0));

        // Last operator wins; ALU held busy for 10 cycles
        key(4'h5); key(4'hB); chk("sub_latched", W'(op_sub), W'(1));
        key(4'hA); chk("add_overwrite", W'(op_sub), W'(0)); chk("stay_b", W'(state), W'(1));
        key(4'h2);
        press_eq(16'h0005, 16'h0002, 1'b0);
        serve(10);

        // 40 + 2 = 42, then chain subtract 1, then repeat with '='
        key(4'hD); key(4'h4); key(4'h0); key(4'hA); key(4'h2);
        press_eq(16'h0040, 16'h0002, 1'b0);
        serve(2);
        key(4'hB);
        chk("chain_opa", opa, 16'h0042); chk("chain_sub", W'(op_sub), W'(1));
        chk("chain_opb", opb, W'(0)); chk("chain_state", W'(state), W'(1));
        key(4'h1); chk("chain_b", opb, 16'h0001);
        press_eq(16'h0042, 16'h0001, 1'b1);
        serve(1);
        press_eq(16'h0041, 16'h0001, 1'b1);
        serve(0);
        key(4'h7);
        chk("new_a_opa", opa, 16'h0007); chk("new_a_state", W'(state), W'(0));

        // Stray ack outside REQ, ignored keys
        alu_ack = 1'b1; alu_result = 16'h9999;
        @(negedge clk);
        alu_ack = 1'b0;
        chk("stray_ack_disp", disp, 16'h0007); chk("stray_ack_state", W'(state), W'(0));
        key(4'hE); chk("key_e_opa", opa, 16'h0007);
        key(4'hC); chk("eq_in_a_state", W'(state), W'(0)); chk("eq_in_a_req", W'(alu_req), W'(0));

        // Reset while a request is outstanding
        key(4'hA);
        press_eq(16'h0007, 16'h0000, 1'b0);
        chk("pend_req", W'(alu_req), W'(1));
        key(4'hD); chk("clr_in_req_state", W'(state), W'(2)); chk("clr_in_req_opa", opa, 16'h0007);
        if (exp_q.size() != 0) begin
            req_t r;
            r = exp_q.pop_front();
            chk("pend_opa", opa, r.a); chk("pend_opb", opb, r.b);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rreq_req", W'(alu_req), W'(0)); chk("rreq_state", W'(state), W'(0));
        chk("rreq_opa", opa, W'(0)); chk("rreq_disp", disp, W'(0));
        alu_ack = 1'b1; alu_result = 16'h1234;
        @(negedge clk);
        alu_ack = 1'b0;
        chk("late_ack_state", W'(state), W'(0)); chk("late_ack_disp", disp, W'(0));
        chk("sb_empty", W'(exp_q.size()), W'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/calc_entry_ctrl.md
Name: calc_entry_ctrl

Overview:
Sequences keypad entry for the calculator datapath. Accepts one 4-bit key code per strobe, shifts BCD digits into operand A or operand B, and latches the operator. On '=' it hands both operands to the ALU over a req/ack handshake and holds the result for display. It sits between the keypad decoder and the arithmetic unit and owns all operand/operator registers.

Parameters:
NDIG, 4, BCD digits per operand; operand width is 4*NDIG bits.

Ports:
clk  in  1  system clock, all logic rising-edge.
reset  in  1  synchronous, active-high.
key_valid  in  1  one-cycle strobe; key_code valid this cycle.
key_code  in  4  0x0-0x9 digit, 0xA add, 0xB sub, 0xC equals, 0xD clear, 0xE/0xF ignored.
key_ready  out  1  high when a key will be consumed this cycle.
opa  out  4*NDIG  operand A, BCD, digit 0 in [3:0].
opb  out  4*NDIG  operand B, BCD.
op_sub  out  1  0 = add, 1 = subtract.
alu_req  out  1  request to ALU; opa/opb/op_sub stable while high.
alu_ack  in  1  ALU completion; alu_result valid in the same cycle.
alu_result  in  4*NDIG  ALU result, BCD.
disp  out  4*NDIG  value to display: A in ENTER_A, B in ENTER_B, held result in SHOW/REQ.
digit_ovf  out  1  sticky; set when a digit is dropped because the operand is full.
state  out  2  0 ENTER_A, 1 ENTER_B, 2 REQ, 3 SHOW.

Behaviour:
- Reset (sampled on rising edge): state=ENTER_A; opa, opb, result, disp = 0; op_sub=0; alu_req=0; digit_ovf=0; per-operand digit counters=0. Reset has priority over every event, including a pending handshake; alu_req falls at that edge.
- Accept: a key is consumed on an edge where key_valid=1 and key_ready=1. key_ready=1 in ENTER_A, ENTER_B and SHOW; key_ready=0 in REQ. Keys offered while key_ready=0 are dropped (see optional feature).
- Digit entry (ENTER_A/ENTER_B): if the count is below NDIG, shift the operand left one nibble, insert the key at [3:0], and increment the count. At count NDIG, leave the operand unchanged and set digit_ovf. Leading zeros count as digits.
- ENTER_A: 0xA/0xB sets op_sub, clears opb and its count, and moves to ENTER_B. An operator with zero digits entered uses A=0. 0xC is ignored.
- ENTER_B: 0xA/0xB overwrites op_sub and stays in ENTER_B. 0xC moves to REQ (B=0 if no digits).
- REQ: alu_req=1 starting the cycle after '=' is consumed. On an edge with alu_ack=1, capture alu_result into the result register, drop alu_req, and go to SHOW. An ack while in a state other than REQ is ignored. There is no timeout.
- SHOW: a digit clears A, loads the digit as A's first digit (count=1), clears digit_ovf, and goes to ENTER_A. 0xA/0xB loads A from the result (count=NDIG), sets op_sub, clears B, and goes to ENTER_B. 0xC repeats the last operation with A=result and the same B and op_sub, then goes to REQ.
- 0xD clear: in any state except REQ it behaves exactly like reset, except it is key-driven. In REQ, 0xD is not consumed.
- 0xE/0xF are consumed and have no effect.
- Latency: key to register/disp update takes 1 cycle. '=' to alu_req takes 1 cycle. alu_ack to disp=result takes 1 cycle.

Optional Feature:
KEY_BUFFER_EN:
- Defined: a one-entry buffer captures the first key offered during REQ; further keys during REQ are dropped and set digit_ovf. In that mode key_ready stays 1 in REQ while the buffer is empty. The buffered key is applied in the first SHOW cycle as if freshly consumed, and external keys are stalled that cycle (key_ready=0).
- Undefined: no buffer; keys offered during REQ are lost.

Test Plan:
- Reset, keys 1,2,0xA,3,0xC → opa=0x0012, opb=0x0003, op_sub=0; alu_req rises the cycle after 0xC; ack with result 0x0015 → disp=0x0015, state=SHOW, alu_req=0.
- Keys 9,8,7,6,5 → opa=0x9876, digit_ovf=1; then 0xD → all registers 0, digit_ovf=0, state=ENTER_A.
- Keys 5,0xB,0xA,2,0xC → op_sub=0 (last operator wins), opb=0x0002; hold alu_ack=0 for 10 cycles → alu_req stays 1, opa/opb stable, key_ready=0.
- From SHOW (result 0x0042): key 0xB,1,0xC → opa=0x0042, op_sub=1, opb=0x0001; then from SHOW a key 7 → opa=0x0007, state=ENTER_A.
- Assert reset while alu_req=1 → next edge alu_req=0, state=ENTER_A, outputs 0; a later alu_ack is ignored.
- KEY_BUFFER_EN: key 4 then key 5 during REQ, then ack → after SHOW, state=ENTER_A with opa=0x0004; digit_ovf=1 because key 5 was dropped.
